// File: rtl/button_pulser_if.sv
// Purpose: groups the five raw button levels and the five single-cycle command
// pulses that button_pulser produces for cursor (up/down/left/right) and card_array (s).
// Ports: master = pulser side (raw in, pulses out); slave = board/consumer side (raw out, pulses in).
interface button_pulser_if;
  logic btn_up_raw;
  logic btn_down_raw;
  logic btn_left_raw;
  logic btn_right_raw;
  logic btn_s_raw;
  logic up;
  logic down;
  logic left;
  logic right;
  logic s;

  modport master (
    input  btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw, btn_s_raw,
    output up, down, left, right, s
  );

  modport slave (
    output btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw, btn_s_raw,
    input  up, down, left, right, s
  );
endinterface

// File: rtl/button_pulser.sv
// Purpose: synchronizes and debounces five raw push-buttons, emitting one one-clock pulse per press.
// Latency: raw high before edge E -> pulse high in the cycle after edge E+DEBOUNCE_CYCLES+1.
// Backpressure: none; pulses are fire-and-forget, and losing direction pulses are dropped, not queued.
// Ports: clk, rst (synchronous, active-high); bus (button_pulser_if.master): btn_*_raw in, up/down/left/right/s out.
// Optional: define BUTTON_PULSER_AUTO_REPEAT_EN to add auto-repeat on held direction buttons.
module button_pulser #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  button_pulser_if.master  bus
);

  // Channel index: 0=up 1=down 2=left 3=right 4=s. Lower index wins among directions.
  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_check
    $error("button_pulser: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   stable;
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   accept;
  logic [NCH-1:0]   rise;
  logic [3:0]       rep;
  logic [3:0]       dir_req;
  logic [NCH-1:0]   pulse_nxt;
  logic [NCH-1:0]   pulse_q;

  assign raw = {bus.btn_s_raw, bus.btn_right_raw, bus.btn_left_raw,
                bus.btn_down_raw, bus.btn_up_raw};

  // A channel accepts its new level on the edge its mismatch count completes.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Only 0->1 acceptances are presses; releases are silent.
  assign rise = accept & sync2;

  // Direction arbitration: losers are discarded this cycle, their stable state still moves.
  always_comb begin
    dir_req      = rise[3:0] | rep;
    pulse_nxt    = '0;
    pulse_nxt[0] = dir_req[0];
    pulse_nxt[1] = dir_req[1] & ~dir_req[0];
    pulse_nxt[2] = dir_req[2] & ~(|dir_req[1:0]);
    pulse_nxt[3] = dir_req[3] & ~(|dir_req[2:0]);
    pulse_nxt[4] = rise[4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      stable  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      pulse_q <= pulse_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BUTTON_PULSER_AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes the next repeat land PERIOD edges later.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold [4];

  // hold is 0 at the press edge, so it reads k-1 on the k-th edge after it.
  always_comb begin
    rep = '0;
    for (int i = 0; i < 4; i++) begin
      rep[i] = stable[i] && !accept[i] && (hold[i] == HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i] || !stable[i]) begin
          hold[i] <= '0;
        end else if (rep[i]) begin
          hold[i] <= HOLD_RELOAD;
        end else begin
          hold[i] <= hold[i] + HOLD_W'(1);
        end
      end
    end
  end
`else
  assign rep = '0;
`endif

  assign bus.up    = pulse_q[0];
  assign bus.down  = pulse_q[1];
  assign bus.left  = pulse_q[2];
  assign bus.right = pulse_q[3];
  assign bus.s     = pulse_q[4];

endmodule
